// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default sizing, scheduler state encoding and flit types.
package noc_pkg;

    localparam int NOC_N_VC       = 2;
    localparam int NOC_CREDIT_MAX = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_t;

    function automatic flit_type_t flit_type(input logic head, input logic tail);
        return flit_type_t'({tail, head});
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int IW = $clog2(N);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_output_scheduler.sv
// Output-port VC scheduler: round-robin packet selection, wormhole locking and
// per-VC downstream credit tracking.
//
//   state  | meaning
//   IDLE   | no packet owns the link; heads arbitrate round-robin from rr_ptr
//   LOCKED | a multi-flit packet on lock_vc owns the link until its tail fires
module vc_output_scheduler
    import noc_pkg::*;
#(
    parameter int N_VC       = NOC_N_VC,
    parameter int CREDIT_MAX = NOC_CREDIT_MAX,
    parameter int CW         = $clog2(CREDIT_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_VC-1:0]         vc_valid,
    input  logic [N_VC-1:0]         vc_head,
    input  logic [N_VC-1:0]         vc_tail,
    input  logic                    out_ready,
    input  logic [N_VC-1:0]         credit_in,
    output logic [N_VC-1:0]         grant,
    output logic                    send_valid,
    output logic [$clog2(N_VC)-1:0] selected_vc,
    output logic [N_VC*CW-1:0]      credit_cnt,
    output logic                    locked,
    output logic                    credit_err,
    output logic                    proto_err
);

    localparam int              IW      = $clog2(N_VC);
    localparam logic [CW-1:0]   CNT_MAX = CW'(CREDIT_MAX);
    localparam logic [IW-1:0]   LAST_VC = IW'(N_VC - 1);

    sched_state_t  state;
    logic [IW-1:0] lock_vc;
    logic [IW-1:0] rr_ptr;

    logic [N_VC-1:0] eligible;
    logic [N_VC-1:0] arb_gnt;
    logic [N_VC-1:0] cerr_hit;
    logic            fire;
    flit_type_t      sel_type;
    logic            sel_head;
    logic            sel_tail;

    function automatic logic [IW-1:0] next_vc(input logic [IW-1:0] vc);
        return (vc == LAST_VC) ? '0 : vc + IW'(1);
    endfunction

    // Only packet heads may compete while the link is free.
    rr_arbiter #(.N(N_VC)) u_rr_arbiter (
        .req (eligible & vc_head),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        grant = '0;
        if (!reset) begin
            if (state == IDLE) begin
                grant = arb_gnt;
            end else if (eligible[lock_vc]) begin
                grant[lock_vc] = 1'b1;
            end
        end
    end

    always_comb begin
        selected_vc = '0;
        for (int i = 0; i < N_VC; i++) begin
            if (grant[i]) begin
                selected_vc = IW'(i);
            end
        end
    end

    assign send_valid = |grant;
    assign fire       = send_valid & out_ready;
    assign sel_type   = flit_type(vc_head[selected_vc], vc_tail[selected_vc]);
    assign sel_head   = (sel_type == FLIT_HEAD) || (sel_type == FLIT_SINGLE);
    assign sel_tail   = (sel_type == FLIT_TAIL) || (sel_type == FLIT_SINGLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lock_vc   <= '0;
            rr_ptr    <= '0;
            locked    <= 1'b0;
            proto_err <= 1'b0;
        end else if (fire) begin
            case (state)
                IDLE: begin
                    if (!sel_head) begin
                        proto_err <= 1'b1;
                    end
                    rr_ptr <= next_vc(selected_vc);
                    if (!sel_tail) begin
                        state   <= LOCKED;
                        lock_vc <= selected_vc;
                        locked  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (sel_head) begin
                        proto_err <= 1'b1;
                    end
                    if (sel_tail) begin
                        state  <= IDLE;
                        rr_ptr <= next_vc(lock_vc);
                        locked <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N_VC; g++) begin : g_credit
        logic          pop;
        logic [CW-1:0] cnt_q;

        assign pop         = grant[g] & out_ready;
        assign eligible[g] = vc_valid[g] & (cnt_q != '0);
        assign cerr_hit[g] = credit_in[g] & ~pop & (cnt_q == CNT_MAX);
        assign credit_cnt[g*CW +: CW] = cnt_q;

        // A pop and a returned credit in the same cycle cancel out.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= CNT_MAX;
            end else if (pop && !credit_in[g]) begin
                cnt_q <= cnt_q - CW'(1);
            end else if (!pop && credit_in[g] && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_err <= 1'b0;
        end else if (|cerr_hit) begin
            credit_err <= 1'b1;
        end
    end

endmodule
